// File: rtl/hps_connection_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and sizing helper for the
// HPS connection mailbox.
package hps_connection_pkg;

  localparam logic [1:0] ADDR_TX_DATA = 2'd0;
  localparam logic [1:0] ADDR_RX_DATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_FULL      = 2;
  localparam int unsigned ST_RX_EMPTY     = 3;
  localparam int unsigned ST_TX_OVF       = 4;
  localparam int unsigned ST_RX_UDF       = 5;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  localparam int unsigned CTRL_TX_FLUSH = 0;
  localparam int unsigned CTRL_RX_FLUSH = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hps_connection_sync_fifo.sv
// Show-ahead synchronous FIFO; push when full and pop when empty are ignored,
// and flush empties it while discarding any same-cycle push/pop.
module hps_connection_sync_fifo
  import hps_connection_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hps_connection_mailbox.sv
// Avalon-MM mailbox: buffered HPS->fabric TX and fabric->HPS RX channels with
// status/control registers. Define HPS_CONNECTION_MAILBOX_IRQ_EN for the irq output.
module hps_connection_mailbox
  import hps_connection_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef HPS_CONNECTION_MAILBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned TX_CW = clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = clog2(RX_DEPTH) + 1;

  logic              wr, rd;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              tx_push, tx_pop, tx_flush;
  logic              rx_push, rx_pop, rx_flush;
  logic              tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       status_word, rx_word, control_word;

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_push  = wr & (address == ADDR_TX_DATA);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = wr & (address == ADDR_CONTROL) & writedata[CTRL_TX_FLUSH];
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd & (address == ADDR_RX_DATA);
  assign rx_flush = wr & (address == ADDR_CONTROL) & writedata[CTRL_RX_FLUSH];
  assign readdata = readdata_q;

  hps_connection_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(writedata[DATA_W-1:0]), .rdata(tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  hps_connection_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .wdata(rx_data), .rdata(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

`ifdef HPS_CONNECTION_MAILBOX_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  assign irq = irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr && address == ADDR_CONTROL) irq_en_d = writedata[CTRL_IRQ_EN];
    irq_d = irq_en_q & (~rx_empty | tx_ovf_q | rx_udf_q);
    control_word = '0;
    control_word[CTRL_IRQ_EN] = irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign control_word = '0;
`endif

  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]  = tx_full;
    status_word[ST_TX_EMPTY] = tx_empty;
    status_word[ST_RX_FULL]  = rx_full;
    status_word[ST_RX_EMPTY] = rx_empty;
    status_word[ST_TX_OVF]   = tx_ovf_q;
    status_word[ST_RX_UDF]   = rx_udf_q;
    status_word[ST_TX_COUNT_LSB +: TX_CW] = tx_count;
    status_word[ST_RX_COUNT_LSB +: RX_CW] = rx_count;
    rx_word = '0;
    rx_word[DATA_W-1:0] = rx_head;
  end

  // Clears are applied before sets so a coincident set wins.
  always_comb begin
    tx_ovf_d   = tx_ovf_q;
    rx_udf_d   = rx_udf_q;
    readdata_d = readdata_q;
    if (wr && address == ADDR_STATUS) begin
      if (writedata[ST_TX_OVF]) tx_ovf_d = 1'b0;
      if (writedata[ST_RX_UDF]) rx_udf_d = 1'b0;
    end
    if (tx_push && tx_full) tx_ovf_d = 1'b1;
    if (rx_pop && rx_empty) rx_udf_d = 1'b1;
    if (rd) begin
      case (address)
        ADDR_RX_DATA: readdata_d = rx_empty ? '0 : rx_word;
        ADDR_STATUS:  readdata_d = status_word;
        ADDR_CONTROL: readdata_d = control_word;
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_hps_connection_mailbox.sv
// Directed bench for hps_connection_mailbox (default 32-bit, depth-8 build);
// irq checks are compiled in with HPS_CONNECTION_MAILBOX_IRQ_EN.
module tb_hps_connection_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef HPS_CONNECTION_MAILBOX_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  hps_connection_mailbox #(.DATA_W(32), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef HPS_CONNECTION_MAILBOX_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic fabric_push(input logic [31:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    writedata = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_readdata", readdata, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
    bus_read(2'd2, rd_val);
    check("rst_status", rd_val, 32'h0000_000A);

    // TX queue and drain in order
    bus_write(2'd0, 32'hDEADBEEF);
    bus_write(2'd0, 32'h12345678);
    check("tx_valid_2", {31'b0, tx_valid}, 32'h1);
    check("tx_head_2", tx_data, 32'hDEADBEEF);
    bus_read(2'd2, rd_val);
    check("status_tx2", rd_val, 32'h0000_0208);
    @(negedge clk); tx_ready = 1'b1;
    check("tx_word0", tx_data, 32'hDEADBEEF);
    @(negedge clk);
    check("tx_word1", tx_data, 32'h12345678);
    @(negedge clk); tx_ready = 1'b0;
    check("tx_drained", {31'b0, tx_valid}, 32'h0);
    bus_read(2'd2, rd_val);
    check("status_drained", rd_val, 32'h0000_000A);
    bus_read(2'd0, rd_val);
    check("tx_data_read0", rd_val, 32'h0);

    // Overflow: nine writes into depth 8
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h100 + 32'(i));
    bus_read(2'd2, rd_val);
    check("status_ovf", rd_val, 32'h0000_0819);
    bus_write(2'd2, 32'h10);
    bus_read(2'd2, rd_val);
    check("status_ovf_clr", rd_val, 32'h0000_0809);
    // Write to a full FIFO during a fabric pop: still dropped
    @(negedge clk);
    tx_ready = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h999;
    @(negedge clk);
    tx_ready = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("full_pop_head", tx_data, 32'h101);
    bus_read(2'd2, rd_val);
    check("status_full_pop", rd_val, 32'h0000_0718);
    bus_write(2'd2, 32'h10);
    bus_write(2'd3, 32'h1);
    bus_read(2'd2, rd_val);
    check("status_after_flush", rd_val, 32'h0000_000A);

    // RX path and underflow
    fabric_push(32'hA5A5A5A5);
    bus_read(2'd1, rd_val);
    check("rx_word", rd_val, 32'hA5A5A5A5);
    bus_read(2'd1, rd_val);
    check("rx_empty_read", rd_val, 32'h0);
    bus_read(2'd2, rd_val);
    check("status_udf", rd_val, 32'h0000_002A);
    bus_write(2'd2, 32'h20);

    // RX full
    for (int i = 0; i < 8; i++) fabric_push(32'h50 + 32'(i));
    check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
    bus_read(2'd2, rd_val);
    check("status_rx_full", rd_val, 32'h0008_0006);
    bus_read(2'd1, rd_val);
    check("rx_first", rd_val, 32'h50);
    // RX flush coinciding with a fabric push
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 32'h77;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
    @(negedge clk);
    rx_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd2, rd_val);
    check("status_rx_flush", rd_val, 32'h0000_000A);

    // TX flush with three queued
    for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h200 + 32'(i));
    bus_write(2'd3, 32'h1);
    check("tx_flush_valid", {31'b0, tx_valid}, 32'h0);
    bus_read(2'd2, rd_val);
    check("status_tx_flush", rd_val, 32'h0000_000A);

`ifdef HPS_CONNECTION_MAILBOX_IRQ_EN
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd_val);
    check("control_irq_en", rd_val, 32'h4);
    check("irq_idle", {31'b0, irq}, 32'h0);
    fabric_push(32'h33);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_read(2'd1, rd_val);
    check("irq_rx_word", rd_val, 32'h33);
    @(negedge clk);
    check("irq_clear", {31'b0, irq}, 32'h0);
`else
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd_val);
    check("control_no_irq", rd_val, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
